rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares one single-port synchronous program ROM between instruction fetch (IF) and data load (LD).
//  Sits between the core's fetch/load units and the ROM array, and sequences one access at a time.
//  Each access is a request/response transaction. LD has priority over IF.
//  A starvation guard ensures IF makes forward progress.
// PARAMETERS
//  WORDS       4096  ROM depth in 32-bit words; word index = addr[31:2]
//  AW          12    ROM word-address width, clog2(WORDS)
//  MEM_LAT     1     cycles from mem_en to valid mem_rdata (1..7)
//  MAX_STARVE  4     consecutive LD grants while IF is pending before IF is forced
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   synchronous, active-high reset
//  if_req      in   1   fetch request; held with if_addr until if_valid
//  if_addr     in   32  fetch byte address (pc)
//  if_valid    out  1   one-cycle pulse: if_rdata/if_err valid
//  if_rdata    out  32  instruction word
//  if_err      out  1   fetch address out of range
//  ld_req      in   1   load request; held with ld_addr until ld_valid
//  ld_addr     in   32  load byte address
//  ld_valid    out  1   one-cycle pulse: ld_rdata/ld_err valid
//  ld_rdata    out  32  data word
//  ld_err      out  1   load address out of range
//  mem_en      out  1   ROM read strobe, one cycle per access
//  mem_addr    out  AW  ROM word index
//  mem_rdata   in   32  ROM read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  Reset: state=IDLE, starve_cnt=0, lat_cnt=0. All outputs are 0 (valid, err, rdata, mem_en, mem_addr).
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
//   IDLE: if any req is asserted, latch the winner and its addr, then go to ISSUE. Otherwise stay.
//   ISSUE: drive mem_en=1 and mem_addr=addr[AW+1:2] for exactly 1 cycle; set lat_cnt=MEM_LAT.
//   WAIT: decrement lat_cnt. When it reaches 0, capture mem_rdata and go to RESP.
//   RESP: pulse the winner's *_valid for 1 cycle with the captured rdata, then return to IDLE.
//  Arbitration in IDLE:
//   ld_req only -> LD.
//   if_req only -> IF.
//   both -> LD, unless starve_cnt==MAX_STARVE, in which case IF wins.
//  starve_cnt:
//   +1 on each LD grant made while if_req=1; saturates at MAX_STARVE.
//   Cleared on any IF grant, and on any grant made while if_req=0.
//  Latency: request seen in IDLE at cycle t -> *_valid at cycle t+2+MEM_LAT (t+3 for MEM_LAT=1).
//   At most one outstanding access.
//   Minimum back-to-back spacing is 3+MEM_LAT cycles.
//  Requests that drop before their valid are protocol violations.
//   The arbiter still completes the latched access and pulses valid.
//  Range check (at latch): addr[31:2] >= WORDS raises an error.
//   No mem_en is issued and rdata=0.
//   The same FSM timing applies, and *_err=1 alongside *_valid.
//  Low addr bits [1:0] are ignored: misaligned addresses round down.
//  rdata/err hold their last value between pulses. Only valid and mem_en are pulses.
//  The non-winning port's valid/err/rdata stay unchanged during a transaction.
//  Reset mid-transaction: the access is abandoned. No valid pulse follows, and state returns to IDLE next cycle.
// TESTING
//  Reset: assert rst 2 cycles -> all outputs 0, mem_en never high.
//  Lone IF: if_addr=0x10, rom[4]=0xDEADBEEF, MEM_LAT=1 -> mem_addr=4; if_valid 3 cycles later; if_rdata=0xDEADBEEF; if_err=0.
//  Simultaneous: if_req and ld_req together -> LD served first; IF served next; each valid pulses exactly once.
//  Starvation: ld_req and if_req held continuously, MAX_STARVE=4 -> grant order LD,LD,LD,LD,IF, repeating.
//  Out of range: ld_addr=0x0000_4000 (word 4096) -> no mem_en; ld_valid with ld_err=1 and ld_rdata=0.
//  Reset mid-WAIT with MEM_LAT=3 -> no valid pulse; next request completes normally.

Source files
------------

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if
//   Bundles the signals around the shared program ROM: the fetch (if_*)
//   request/response pair, the load (ld_*) request/response pair and the
//   ROM read port (mem_*).
//
//   modport slave  : the arbiter's view. It takes requests and ROM read
//                    data, and it drives responses and the ROM strobe/address.
//   modport master : the view of the core plus ROM array. It is the
//                    mirror image of slave.
//
//   Parameter AW sets the ROM word-address width. It must match the
//   arbiter's AW.
interface rom_port_arbiter_if #(
  parameter int AW = 12
);

  // instruction fetch port
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_valid;
  logic [31:0]   if_rdata;
  logic          if_err;

  // data load port
  logic          ld_req;
  logic [31:0]   ld_addr;
  logic          ld_valid;
  logic [31:0]   ld_rdata;
  logic          ld_err;

  // ROM read port
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  modport slave (
    input  if_req,
    input  if_addr,
    output if_valid,
    output if_rdata,
    output if_err,
    input  ld_req,
    input  ld_addr,
    output ld_valid,
    output ld_rdata,
    output ld_err,
    output mem_en,
    output mem_addr,
    input  mem_rdata
  );

  modport master (
    output if_req,
    output if_addr,
    input  if_valid,
    input  if_rdata,
    input  if_err,
    output ld_req,
    output ld_addr,
    input  ld_valid,
    input  ld_rdata,
    input  ld_err,
    input  mem_en,
    input  mem_addr,
    output mem_rdata
  );

endinterface

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Lets instruction fetch (IF) and data load (LD) share one single-port
//   synchronous program ROM. Only one access is in flight at a time. Each
//   access moves through IDLE -> ISSUE -> WAIT -> RESP.
//   LD normally wins when both ports request. However, after MAX_STARVE
//   consecutive LD grants with IF waiting, IF is forced through so that
//   fetch always makes forward progress.
//
// Parameters
//   WORDS      ROM depth in 32-bit words. Byte addresses whose word index
//              is >= WORDS are rejected with *_err.
//   AW         ROM word-address width, clog2(WORDS).
//   MEM_LAT    Number of cycles from mem_en to valid mem_rdata (1..7).
//   MAX_STARVE Number of consecutive LD grants allowed while IF waits.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   bus        rom_port_arbiter_if.slave
//                if_req/if_addr   -> fetch request, held until if_valid
//                if_valid         <- one-cycle response pulse
//                if_rdata/if_err  <- response data/error, held between pulses
//                ld_*             same as the IF port, for loads
//                mem_en/mem_addr  -> ROM read strobe and word index
//                mem_rdata        <- ROM data, MEM_LAT cycles after mem_en
//
// Timing
//   A request sampled in IDLE at cycle t produces *_valid at cycle
//   t+2+MEM_LAT. The minimum spacing between responses is 3+MEM_LAT cycles.
module rom_port_arbiter #(
  parameter int WORDS      = 4096,
  parameter int AW         = 12,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STARVE = 4
) (
  input logic               clk,
  input logic               rst,
  rom_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam int LW = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    SRC_IF,
    SRC_LD
  } src_t;

  state_t        state;
  state_t        next_state;

  // details of the access currently in flight, latched when it is granted
  src_t          winner_q;
  logic [AW-1:0] addr_q;
  logic          err_q;

  logic [SW-1:0] starve_cnt;
  logic [LW-1:0] lat_cnt;

  // response registers; each port keeps its last response until its next one
  logic [31:0]   if_rdata_q;
  logic [31:0]   ld_rdata_q;
  logic          if_err_q;
  logic          ld_err_q;

  // arbitration signals, only meaningful while in IDLE
  logic          starved;
  logic          grant_any;
  logic          grant_ld;
  logic [31:0]   sel_addr;
  logic          out_of_range;

  // Address bits [1:0] do not select a word, so misaligned addresses round
  // down. This gathers them so it is clear they are deliberately dropped.
  logic          unused_addr_bits;

  // IF is forced through only when it is actually waiting and the
  // starvation count has reached its limit. Otherwise LD has priority.
  // The range check is applied to the winning address, so a bad address
  // is caught before any ROM strobe is issued.
  always_comb begin
    starved      = (starve_cnt == SW'(MAX_STARVE));
    grant_any    = bus.if_req | bus.ld_req;
    grant_ld     = bus.ld_req & ~(bus.if_req & starved);
    sel_addr     = grant_ld ? bus.ld_addr : bus.if_addr;
    out_of_range = ({2'b00, sel_addr[31:2]} >= 32'(WORDS));
  end

  assign unused_addr_bits = ^sel_addr[1:0];

  // State register. A reset abandons any access in flight: the FSM simply
  // returns to IDLE, and no valid pulse is produced for that access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. WAIT moves on during the cycle in which the latency
  // counter is about to reach zero. That is the cycle in which the ROM data
  // for the access is on mem_rdata, and it is captured at that same edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_any) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (lat_cnt == LW'(1)) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output logic. The ROM strobe is suppressed for out-of-range accesses.
  // Such accesses still follow the normal state sequence, so their response
  // timing matches a real read. The valid pulse goes only to the port that
  // won the access.
  always_comb begin
    bus.mem_en   = 1'b0;
    bus.mem_addr = '0;
    bus.if_valid = 1'b0;
    bus.ld_valid = 1'b0;
    case (state)
      ISSUE: begin
        if (!err_q) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = addr_q;
        end
      end
      RESP: begin
        if (winner_q == SRC_LD) begin
          bus.ld_valid = 1'b1;
        end else begin
          bus.if_valid = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.if_rdata = if_rdata_q;
  assign bus.if_err   = if_err_q;
  assign bus.ld_rdata = ld_rdata_q;
  assign bus.ld_err   = ld_err_q;

  // Grant bookkeeping and the latency counter. starve_cnt counts only LD
  // grants that passed over a waiting IF. Any other grant clears it: either
  // IF was served, or nobody was being starved.
  always_ff @(posedge clk) begin
    if (rst) begin
      winner_q   <= SRC_IF;
      addr_q     <= '0;
      err_q      <= 1'b0;
      starve_cnt <= '0;
      lat_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            winner_q <= grant_ld ? SRC_LD : SRC_IF;
            addr_q   <= sel_addr[AW+1:2];
            err_q    <= out_of_range;
            if (grant_ld && bus.if_req) begin
              if (!starved) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        ISSUE: begin
          lat_cnt <= LW'(MEM_LAT);
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Response capture. Only the winning port's registers change, and they
  // change at the edge that enters RESP, so new data appears together with
  // the valid pulse. An out-of-range access returns zero data with err set.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q <= '0;
      ld_rdata_q <= '0;
      if_err_q   <= 1'b0;
      ld_err_q   <= 1'b0;
    end else if (state == WAIT && lat_cnt == LW'(1)) begin
      if (winner_q == SRC_LD) begin
        ld_rdata_q <= err_q ? 32'h0 : bus.mem_rdata;
        ld_err_q   <= err_q;
      end else begin
        if_rdata_q <= err_q ? 32'h0 : bus.mem_rdata;
        if_err_q   <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter
//   Drives two arbiter instances. dut_a uses MEM_LAT=1 and runs the
//   directed and randomized traffic. dut_b uses MEM_LAT=3 and covers a
//   reset that arrives while an access is waiting on the ROM.
//   A behavioural ROM with the matching latency sits behind each instance.
//   The expected grant order, response cycle and response data come from
//   the arbitration rules, applied per transaction.
module tb_rom_port_arbiter;

  localparam int WORDS      = 4096;
  localparam int AW         = 12;
  localparam int MAX_STARVE = 4;
  localparam int LAT_A      = 1;
  localparam int LAT_B      = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_b;

  int compared   = 0;
  int mismatched = 0;

  rom_port_arbiter_if #(.AW(AW)) bus_a ();
  rom_port_arbiter_if #(.AW(AW)) bus_b ();

  rom_port_arbiter #(
    .WORDS(WORDS), .AW(AW), .MEM_LAT(LAT_A), .MAX_STARVE(MAX_STARVE)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  rom_port_arbiter #(
    .WORDS(WORDS), .AW(AW), .MEM_LAT(LAT_B), .MAX_STARVE(MAX_STARVE)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(bus_b)
  );

  // ROM contents, plus one read pipeline per instance. Outside the cycle
  // in which read data is due, mem_rdata carries a marker value. A capture
  // in the wrong cycle therefore shows up as wrong data.
  logic [31:0] rom [WORDS];

  logic        en_a  [LAT_A] = '{default: 1'b0};
  logic [31:0] dat_a [LAT_A];
  logic        en_b  [LAT_B] = '{default: 1'b0};
  logic [31:0] dat_b [LAT_B];

  always @(posedge clk) begin
    for (int i = LAT_A - 1; i > 0; i--) begin
      en_a[i]  <= en_a[i-1];
      dat_a[i] <= dat_a[i-1];
    end
    en_a[0]  <= bus_a.mem_en;
    dat_a[0] <= rom[bus_a.mem_addr];
  end

  always @(posedge clk) begin
    for (int i = LAT_B - 1; i > 0; i--) begin
      en_b[i]  <= en_b[i-1];
      dat_b[i] <= dat_b[i-1];
    end
    en_b[0]  <= bus_b.mem_en;
    dat_b[0] <= rom[bus_b.mem_addr];
  end

  assign bus_a.mem_rdata = en_a[LAT_A-1] ? dat_a[LAT_A-1] : 32'hBAD0_BAD0;
  assign bus_b.mem_rdata = en_b[LAT_B-1] ? dat_b[LAT_B-1] : 32'hBAD0_BAD0;

  // Reference model state for dut_a
  int          starve;
  bit          if_pend;
  bit          ld_pend;
  logic [31:0] m_if_addr;
  logic [31:0] m_ld_addr;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_ld_rdata;
  logic        exp_if_err;
  logic        exp_ld_err;
  bit          obs_order[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0) begin
      a = $urandom | 32'h0000_4000;
    end else begin
      a = (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(0, 3));
    end
    return a;
  endfunction

  task automatic clearModel();
    starve       = 0;
    if_pend      = 0;
    ld_pend      = 0;
    exp_if_rdata = '0;
    exp_ld_rdata = '0;
    exp_if_err   = 1'b0;
    exp_ld_err   = 1'b0;
  endtask

  task automatic resetA();
    rst          = 1'b1;
    bus_a.if_req = 1'b0;
    bus_a.ld_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_valids", 32'({bus_a.if_valid, bus_a.ld_valid}), 32'd0);
      checkOutput("rst_errs", 32'({bus_a.if_err, bus_a.ld_err}), 32'd0);
      checkOutput("rst_if_rdata", bus_a.if_rdata, 32'd0);
      checkOutput("rst_ld_rdata", bus_a.ld_rdata, 32'd0);
      checkOutput("rst_mem_en", 32'(bus_a.mem_en), 32'd0);
      checkOutput("rst_mem_addr", 32'(bus_a.mem_addr), 32'd0);
    end
    rst = 1'b0;
    clearModel();
  endtask

  // Raises requests at a negedge that falls inside an IDLE cycle
  task automatic applyStimulus(input bit raise_if, input logic [31:0] if_a,
                               input bit raise_ld, input logic [31:0] ld_a);
    if (raise_if) begin
      bus_a.if_req  = 1'b1;
      bus_a.if_addr = if_a;
      m_if_addr     = if_a;
      if_pend       = 1;
    end
    if (raise_ld) begin
      bus_a.ld_req  = 1'b1;
      bus_a.ld_addr = ld_a;
      m_ld_addr     = ld_a;
      ld_pend       = 1;
    end
  endtask

  // One transaction on dut_a, from an IDLE-cycle negedge to the next one
  task automatic runRound(input bit drop_winner);
    bit          win_ld;
    bit          e;
    logic [31:0] a;
    logic [31:0] d;
    if (!if_pend && !ld_pend) begin
      @(negedge clk);
      checkOutput("idle_valids", 32'({bus_a.if_valid, bus_a.ld_valid}), 32'd0);
      checkOutput("idle_mem_en", 32'(bus_a.mem_en), 32'd0);
      return;
    end
    win_ld = ld_pend && !(if_pend && starve == MAX_STARVE);
    if (win_ld && if_pend) begin
      starve = (starve == MAX_STARVE) ? starve : starve + 1;
    end else begin
      starve = 0;
    end
    a = win_ld ? m_ld_addr : m_if_addr;
    e = (a >> 2) >= 32'(WORDS);
    if (e) d = 32'h0;
    else   d = rom[a >> 2];

    @(negedge clk);
    if (drop_winner) begin
      if (win_ld) begin bus_a.ld_req = 1'b0; ld_pend = 0; end
      else        begin bus_a.if_req = 1'b0; if_pend = 0; end
    end
    checkOutput("issue_mem_en", 32'(bus_a.mem_en), 32'(!e));
    if (!e) checkOutput("issue_mem_addr", 32'(bus_a.mem_addr), a >> 2);
    checkOutput("issue_valids", 32'({bus_a.if_valid, bus_a.ld_valid}), 32'd0);

    for (int k = 0; k < LAT_A; k++) begin
      @(negedge clk);
      checkOutput("wait_valids", 32'({bus_a.if_valid, bus_a.ld_valid}), 32'd0);
      checkOutput("wait_mem_en", 32'(bus_a.mem_en), 32'd0);
    end

    @(negedge clk);
    checkOutput("resp_valids", 32'({bus_a.if_valid, bus_a.ld_valid}),
                win_ld ? 32'd1 : 32'd2);
    obs_order.push_back(bus_a.ld_valid);
    if (win_ld) begin
      exp_ld_rdata = d; exp_ld_err = e;
      bus_a.ld_req = 1'b0; ld_pend = 0;
    end else begin
      exp_if_rdata = d; exp_if_err = e;
      bus_a.if_req = 1'b0; if_pend = 0;
    end
    checkOutput("resp_if_rdata", bus_a.if_rdata, exp_if_rdata);
    checkOutput("resp_if_err", 32'(bus_a.if_err), 32'(exp_if_err));
    checkOutput("resp_ld_rdata", bus_a.ld_rdata, exp_ld_rdata);
    checkOutput("resp_ld_err", 32'(bus_a.ld_err), 32'(exp_ld_err));

    @(negedge clk);
    checkOutput("post_valids", 32'({bus_a.if_valid, bus_a.ld_valid}), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) rom[i] = $urandom;
    rom[4] = 32'hDEAD_BEEF;
    bus_a.if_req = 1'b0; bus_a.if_addr = '0;
    bus_a.ld_req = 1'b0; bus_a.ld_addr = '0;
    bus_b.if_req = 1'b0; bus_b.if_addr = '0;
    bus_b.ld_req = 1'b0; bus_b.ld_addr = '0;
    rst_b = 1'b1;
    m_if_addr = '0;
    m_ld_addr = '0;
    clearModel();

    // reset held for two cycles
    resetA();
    rst_b = 1'b0;

    // lone fetch of word 4
    applyStimulus(1, 32'h10, 0, 32'h0);
    runRound(0);
    checkOutput("lone_if_rdata", bus_a.if_rdata, 32'hDEAD_BEEF);
    checkOutput("lone_if_err", 32'(bus_a.if_err), 32'd0);

    // simultaneous requests: LD first, then IF
    applyStimulus(1, 32'h20, 1, 32'h104);
    runRound(0);
    runRound(0);

    // out-of-range load, then a misaligned fetch that rounds down to word 4
    applyStimulus(0, 32'h0, 1, 32'h0000_4000);
    runRound(0);
    checkOutput("oor_ld_err", 32'(bus_a.ld_err), 32'd1);
    checkOutput("oor_ld_rdata", bus_a.ld_rdata, 32'd0);
    applyStimulus(1, 32'h13, 0, 32'h0);
    runRound(0);
    checkOutput("misaligned_if_rdata", bus_a.if_rdata, 32'hDEAD_BEEF);

    // both held continuously: expect LD,LD,LD,LD,IF repeating
    resetA();
    obs_order.delete();
    for (int r = 0; r < 10; r++) begin
      applyStimulus(!if_pend, randAddr(), !ld_pend, randAddr());
      runRound(0);
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("starve_order_%0d", i), 32'(obs_order[i]),
                  (i % 5 == 4) ? 32'd0 : 32'd1);
    end

    // request dropped after its grant still completes
    applyStimulus(!if_pend, 32'h44, 0, 32'h0);
    runRound(1);

    // randomized traffic
    for (int r = 0; r < 200; r++) begin
      applyStimulus(!if_pend && ($urandom_range(0, 2) != 0), randAddr(),
                    !ld_pend && ($urandom_range(0, 2) != 0), randAddr());
      runRound($urandom_range(0, 15) == 0);
    end
    bus_a.if_req = 1'b0;
    bus_a.ld_req = 1'b0;

    // dut_b: reset while waiting on a 3-cycle ROM, then a normal load
    @(negedge clk);
    bus_b.if_addr = 32'h40;
    bus_b.if_req  = 1'b1;
    @(negedge clk);
    checkOutput("b_issue_mem_en", 32'(bus_b.mem_en), 32'd1);
    checkOutput("b_issue_mem_addr", 32'(bus_b.mem_addr), 32'h10);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    bus_b.if_req = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("b_abandon_valids", 32'({bus_b.if_valid, bus_b.ld_valid}), 32'd0);
      checkOutput("b_abandon_mem_en", 32'(bus_b.mem_en), 32'd0);
    end
    checkOutput("b_abandon_if_rdata", bus_b.if_rdata, 32'd0);
    bus_b.ld_addr = 32'h82;
    bus_b.ld_req  = 1'b1;
    @(negedge clk);
    checkOutput("b_ld_mem_addr", 32'(bus_b.mem_addr), 32'd32);
    for (int k = 0; k < LAT_B; k++) begin
      @(negedge clk);
      checkOutput("b_ld_wait_valids", 32'({bus_b.if_valid, bus_b.ld_valid}), 32'd0);
    end
    @(negedge clk);
    checkOutput("b_ld_valids", 32'({bus_b.if_valid, bus_b.ld_valid}), 32'd1);
    checkOutput("b_ld_rdata", bus_b.ld_rdata, rom[32]);
    checkOutput("b_ld_err", 32'(bus_b.ld_err), 32'd0);
    checkOutput("b_if_rdata_held", bus_b.if_rdata, 32'd0);
    bus_b.ld_req = 1'b0;
    @(negedge clk);
    checkOutput("b_post_valids", 32'({bus_b.if_valid, bus_b.ld_valid}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
